// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch stage.
// Fetch requests are accepted on a valid/ready handshake and travel through a
// fixed-length read pipeline. They then land in an in-order response FIFO that
// the fetch stage drains with its own valid/ready handshake. A flush from the
// fetch stage (PC redirect) discards every stale response still in flight.
// A word write port loads the program image.
module imem_fetch_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = LATENCY + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_pc,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_pc,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        wr_en,
    input  logic [63:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int          WORDS    = 1 << DEPTH_LOG2;
    localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Address decode results for the fetch and write ports
    logic [63:0]           req_off;
    logic [63:0]           wr_off;
    logic                  req_err;
    logic                  wr_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;

    // Instruction storage
    logic [31:0] mem [WORDS];

    // Read pipeline: stage 0 is loaded at the accept edge, the last stage
    // feeds the response FIFO
    logic [LATENCY-1:0] pipe_valid;
    logic [63:0]        pipe_pc   [LATENCY];
    logic [31:0]        pipe_inst [LATENCY];
    logic [LATENCY-1:0] pipe_err;

    // Response FIFO storage and bookkeeping
    logic [63:0]           fifo_pc   [FIFO_DEPTH];
    logic [31:0]           fifo_inst [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_err;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      out_cnt;

    // Handshake events
    logic accept;
    logic push;
    logic pop;

    // Ring-buffer pointer advance; the FIFO depth need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode both addresses; the offset wraps modulo 2**64, so anything below
    // the base shows up as a huge offset as well as failing the compare.
    // BASE_ADDR is word aligned, so the low offset bits equal the low PC bits.
    always_comb begin
        req_off = req_pc - BASE_ADDR;
        wr_off  = wr_addr - BASE_ADDR;
        req_err = (req_off[1:0] != 2'b00) || (req_pc < BASE_ADDR) ||
                  (req_off[63:DEPTH_LOG2+2] != '0);
        wr_err  = (wr_off[1:0] != 2'b00) || (wr_addr < BASE_ADDR) ||
                  (wr_off[63:DEPTH_LOG2+2] != '0);
        req_idx = req_off[DEPTH_LOG2+1:2];
        wr_idx  = wr_off[DEPTH_LOG2+1:2];
    end

    // Handshake decode: outstanding work never exceeds the FIFO size, so the
    // pipeline never has to stall and a push always finds a free slot
    always_comb begin
        req_ready  = (out_cnt < CNT_W'(FIFO_DEPTH));
        accept     = req_valid && req_ready;
        resp_valid = (fifo_count != '0);
        pop        = resp_valid && resp_ready;
        push       = pipe_valid[LATENCY-1] && !flush;
    end

    // Memory write; error addresses are dropped, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en && !wr_err) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Pipeline data path; the read happens at the accept edge so a write in
    // the same cycle is not yet visible, and error fetches never touch memory
    always_ff @(posedge clk) begin
        if (accept) begin
            pipe_pc[0]  <= req_pc;
            pipe_err[0] <= req_err;
            pipe_inst[0] <= req_err ? NOP_INST : mem[req_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_pc[i]   <= pipe_pc[i-1];
            pipe_err[i]  <= pipe_err[i-1];
            pipe_inst[i] <= pipe_inst[i-1];
        end
    end

    // Pipeline valid bits; a flush kills everything older but keeps a
    // request accepted in the flush cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] && !flush;
            end
        end
    end

    // FIFO storage write from the last pipeline stage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= pipe_pc[LATENCY-1];
            fifo_inst[wr_ptr] <= pipe_inst[LATENCY-1];
            fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
        end
    end

    // FIFO pointers, occupancy and outstanding-request count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_cnt    <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_cnt    <= CNT_W'(accept);
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            out_cnt    <= out_cnt + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Response outputs show the FIFO head and read as zero while empty
    always_comb begin
        resp_pc   = '0;
        resp_inst = '0;
        resp_err  = 1'b0;
        if (resp_valid) begin
            resp_pc   = fifo_pc[rd_ptr];
            resp_inst = fifo_inst[rd_ptr];
            resp_err  = fifo_err[rd_ptr];
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed testbench for imem_fetch_responder with default parameters
// (LATENCY=2, FIFO_DEPTH=3, 4096 words at 0x8000_0000).
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_pc;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int accepted;

    logic [63:0] exp_pc   [8];
    logic [31:0] exp_inst [8];
    logic        exp_err  [8];

    imem_fetch_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pc    (resp_pc),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch request (and optional flush) for exactly one edge
    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic fl);
        req_valid = v;
        req_pc    = pc;
        flush     = fl;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic writeWord(input logic [63:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Consume responses for a bounded number of cycles and compare them in
    // order against exp_*; the final count catches missing or extra ones
    task automatic drainExpect(input string tag, input int n, input int budget);
        int got;
        got = 0;
        for (int c = 0; c < budget; c++) begin
            if (resp_valid) begin
                if (got < n) begin
                    checkOutput({tag, "_pc"},   resp_pc,   exp_pc[got]);
                    checkOutput({tag, "_inst"}, {32'h0, resp_inst}, {32'h0, exp_inst[got]});
                    checkOutput({tag, "_err"},  {63'h0, resp_err},  {63'h0, exp_err[got]});
                end
                got++;
            end
            tick();
        end
        checkOutput({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_pc     = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_req_ready",  {63'h0, req_ready},  64'h1);
        checkOutput("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        checkOutput("rst_resp_pc",    resp_pc,             64'h0);
        checkOutput("rst_resp_inst",  {32'h0, resp_inst},  64'h0);
        checkOutput("rst_resp_err",   {63'h0, resp_err},   64'h0);

        // Program image
        writeWord(64'h8000_0000, 32'h0000_0093);
        writeWord(64'h8000_0004, 32'h0010_0113);
        writeWord(64'h8000_0008, 32'h0020_0193);
        writeWord(64'h8000_000C, 32'h0030_0213);
        writeWord(64'h8000_0010, 32'h1111_1111);
        writeWord(64'h8000_0100, 32'h0050_0293);

        // Test 1: back-to-back fetches, exact latency and throughput
        req_valid = 1'b1;
        req_pc    = 64'h8000_0000;
        tick();
        req_pc    = 64'h8000_0004;
        tick();
        req_valid = 1'b0;
        checkOutput("t1_early_valid", {63'h0, resp_valid}, 64'h0);
        tick();
        checkOutput("t1_r0_valid", {63'h0, resp_valid}, 64'h1);
        checkOutput("t1_r0_pc",    resp_pc,             64'h8000_0000);
        checkOutput("t1_r0_inst",  {32'h0, resp_inst},  64'h0000_0093);
        checkOutput("t1_r0_err",   {63'h0, resp_err},   64'h0);
        tick();
        checkOutput("t1_r1_valid", {63'h0, resp_valid}, 64'h1);
        checkOutput("t1_r1_pc",    resp_pc,             64'h8000_0004);
        checkOutput("t1_r1_inst",  {32'h0, resp_inst},  64'h0010_0113);
        checkOutput("t1_r1_err",   {63'h0, resp_err},   64'h0);
        tick();
        checkOutput("t1_done_valid", {63'h0, resp_valid}, 64'h0);

        // Test 2: backpressure fills the responder, head stays stable
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        accepted   = 0;
        for (int c = 0; c < 8; c++) begin
            req_pc = 64'h8000_0000 + 64'(4 * accepted);
            if (resp_valid) begin
                checkOutput("t2_stall_pc", resp_pc, 64'h8000_0000);
            end
            if (req_ready) begin
                accepted++;
            end
            tick();
        end
        req_valid = 1'b0;
        checkOutput("t2_accept_count", 64'(accepted), 64'd3);
        checkOutput("t2_req_ready",   {63'h0, req_ready},  64'h0);
        checkOutput("t2_head_valid",  {63'h0, resp_valid}, 64'h1);
        checkOutput("t2_head_inst",   {32'h0, resp_inst},  64'h0000_0093);
        exp_pc[0] = 64'h8000_0000; exp_inst[0] = 32'h0000_0093; exp_err[0] = 1'b0;
        exp_pc[1] = 64'h8000_0004; exp_inst[1] = 32'h0010_0113; exp_err[1] = 1'b0;
        exp_pc[2] = 64'h8000_0008; exp_inst[2] = 32'h0020_0193; exp_err[2] = 1'b0;
        resp_ready = 1'b1;
        drainExpect("t2", 3, 6);
        checkOutput("t2_ready_after", {63'h0, req_ready}, 64'h1);

        // Test 3: flush discards older fetches, keeps the one issued with it
        applyStimulus(1'b1, 64'h8000_0008, 1'b0);
        applyStimulus(1'b1, 64'h8000_000C, 1'b0);
        applyStimulus(1'b1, 64'h8000_0100, 1'b1);
        checkOutput("t3_post_flush_valid", {63'h0, resp_valid}, 64'h0);
        exp_pc[0] = 64'h8000_0100; exp_inst[0] = 32'h0050_0293; exp_err[0] = 1'b0;
        drainExpect("t3", 1, 6);

        // Test 4: misaligned, below base and past the end all report errors
        applyStimulus(1'b1, 64'h8000_0002, 1'b0);
        applyStimulus(1'b1, 64'h7FFF_FFFC, 1'b0);
        applyStimulus(1'b1, 64'h8000_4000, 1'b0);
        exp_pc[0] = 64'h8000_0002; exp_inst[0] = 32'h0000_0013; exp_err[0] = 1'b1;
        exp_pc[1] = 64'h7FFF_FFFC; exp_inst[1] = 32'h0000_0013; exp_err[1] = 1'b1;
        exp_pc[2] = 64'h8000_4000; exp_inst[2] = 32'h0000_0013; exp_err[2] = 1'b1;
        drainExpect("t4", 3, 6);

        // Test 5: read in the write cycle sees old data, next read sees new
        wr_en     = 1'b1;
        wr_addr   = 64'h8000_0010;
        wr_data   = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 64'h8000_0010, 1'b0);
        wr_en     = 1'b0;
        applyStimulus(1'b1, 64'h8000_0010, 1'b0);
        exp_pc[0] = 64'h8000_0010; exp_inst[0] = 32'h1111_1111; exp_err[0] = 1'b0;
        exp_pc[1] = 64'h8000_0010; exp_inst[1] = 32'hDEAD_BEEF; exp_err[1] = 1'b0;
        drainExpect("t5", 2, 6);

        // Test 6: reset with two fetches in flight drops them both
        applyStimulus(1'b1, 64'h8000_0000, 1'b0);
        applyStimulus(1'b1, 64'h8000_0004, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_resp_valid", {63'h0, resp_valid}, 64'h0);
        checkOutput("t6_req_ready",  {63'h0, req_ready},  64'h1);
        checkOutput("t6_resp_pc",    resp_pc,             64'h0);
        drainExpect("t6", 0, 6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
